// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: latch enables/flushes, PC control, data-wait watchdog.
// Optional statistics counters are built when HAZARD_STATS_EN is defined. state_dbg_o encoding: 0 RUN, 1 DWAIT, 2 HALTED.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int DTIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_Branch,
  input  logic             mem_bne,
  input  logic             mem_zero,
  input  logic             mem_Jump,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             halt_out,
  output logic             err,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALTED = 2'd2} state_e;

  typedef struct packed {
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_flush;
    logic       exmem_en;
    logic       exmem_flush;
    logic       memwb_en;
    logic       memwb_flush;
    logic       pc_en;
    logic [1:0] pc_sel;
  } ctrl_t;

  localparam int WCNT_W = $clog2(DTIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(DTIMEOUT);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q;
  ctrl_t             ctrl_c;
  logic              dstall, taken, load_use;

  assign dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  assign taken    = mem_Branch & (mem_zero ^ mem_bne);
  assign load_use = ex_dREN & (ex_wsel != '0) & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  // A flushed latch is also enabled so that the bubble is actually captured.
  always_comb begin
    ctrl_c  = '0;
    state_d = state_q;
    if (state_q != HALTED) begin
      state_d = RUN;
      if (dstall) begin
        ctrl_c.memwb_en    = 1'b1;
        ctrl_c.memwb_flush = 1'b1;
        state_d            = DWAIT;
      end else if (mem_halt) begin
        ctrl_c.memwb_en = 1'b1;
        state_d         = HALTED;
      end else if (mem_Jump | taken) begin
        ctrl_c             = '{default: 1'b1, memwb_flush: 1'b0, pc_sel: 2'd0};
        ctrl_c.pc_sel      = mem_Jump ? 2'd2 : 2'd1;
      end else if (load_use) begin
        ctrl_c.idex_en    = 1'b1;
        ctrl_c.idex_flush = 1'b1;
        ctrl_c.exmem_en   = 1'b1;
        ctrl_c.memwb_en   = 1'b1;
      end else if (!ihit) begin
        ctrl_c.ifid_en    = 1'b1;
        ctrl_c.ifid_flush = 1'b1;
        ctrl_c.idex_en    = 1'b1;
        ctrl_c.exmem_en   = 1'b1;
        ctrl_c.memwb_en   = 1'b1;
      end else begin
        ctrl_c.ifid_en  = 1'b1;
        ctrl_c.idex_en  = 1'b1;
        ctrl_c.exmem_en = 1'b1;
        ctrl_c.memwb_en = 1'b1;
        ctrl_c.pc_en    = 1'b1;
      end
    end
  end

  // Only stalled cycles spent in DWAIT count; the cycle that enters DWAIT does not.
  always_comb begin
    wcnt_d = '0;
    if (state_q == DWAIT && dstall)
      wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + WCNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_q | (wcnt_q == WMAX);
    end
  end

  assign {ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
          memwb_en, memwb_flush, pc_en, pc_sel} = RST ? '0 : ctrl_c;
  assign halt_out    = ~RST & (state_q == HALTED);
  assign err         = ~RST & err_q;
  assign state_dbg_o = RST ? 2'd0 : state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q, flush_q;

  // exmem_flush is raised only by a branch/jump redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl_c.pc_en && state_q != HALTED) stall_q <= stall_q + 32'd1;
      if (ctrl_c.exmem_flush)                 flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = RST ? '0 : stall_q;
  assign flush_events = RST ? '0 : flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs. a rule-table model.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int TO    = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST, ihit, dhit, mem_dREN, mem_dWEN, mem_Branch, mem_bne, mem_zero;
  logic             mem_Jump, mem_halt, ex_dREN;
  logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
  logic             ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
  logic             memwb_en, memwb_flush, pc_en, halt_out, err;
  logic [1:0]       pc_sel, state_dbg;
  logic [31:0]      stall_cycles, flush_events;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .DTIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_Branch(mem_Branch), .mem_bne(mem_bne), .mem_zero(mem_zero), .mem_Jump(mem_Jump),
    .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .pc_en(pc_en), .pc_sel(pc_sel), .halt_out(halt_out), .err(err),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .state_dbg_o(state_dbg)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          miss_len = 0;
  bit          m_wait, m_halt, m_err;
  int          m_cnt;
  logic [31:0] m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_Branch = 1'b0;
    mem_bne = 1'b0; mem_zero = 1'b0; mem_Jump = 1'b0; mem_halt = 1'b0; ex_dREN = 1'b0;
    ex_wsel = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic rand_inputs();
    if (miss_len == 0 && $urandom_range(0, 25) == 0) miss_len = $urandom_range(3, 8);
    ihit       = ($urandom_range(0, 9) != 0);
    mem_dREN   = (miss_len > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
    mem_dWEN   = ($urandom_range(0, 7) == 0);
    dhit       = (miss_len > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    mem_Branch = ($urandom_range(0, 4) == 0);
    mem_bne    = 1'($urandom_range(0, 1));
    mem_zero   = 1'($urandom_range(0, 1));
    mem_Jump   = ($urandom_range(0, 9) == 0);
    mem_halt   = ($urandom_range(0, 59) == 0);
    ex_dREN    = 1'($urandom_range(0, 1));
    ex_wsel    = REG_W'($urandom_range(0, 3));
    id_rs      = REG_W'($urandom_range(0, 3));
    id_rt      = REG_W'($urandom_range(0, 3));
    if (miss_len > 0) miss_len--;
  endtask

  // Outputs are compared at the falling edge; the model advances at the rising edge.
  task automatic cycle();
    logic [12:0] exp_v, got_v;
    logic [1:0]  exp_st;
    logic [31:0] exp_stall, exp_flush;
    bit          ds, tk, lu;
    int          rule;
    @(negedge CLK);
    ds = (mem_dREN || mem_dWEN) && !dhit;
    tk = mem_Branch && (mem_zero ^ mem_bne);
    lu = ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || ex_wsel == id_rt);
    if (RST)                  rule = -1;
    else if (m_halt)          rule = 0;
    else if (ds)              rule = 1;
    else if (mem_halt)        rule = 2;
    else if (mem_Jump || tk)  rule = 3;
    else if (lu)              rule = 4;
    else if (!ihit)           rule = 5;
    else                      rule = 6;
    // Latch bits: ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl; then pc_en, pc_sel, halt, err.
    case (rule)
      0:       exp_v = {8'b0000_0000, 1'b0, 2'd0, 1'b1, m_err};
      1:       exp_v = {8'b0000_0011, 1'b0, 2'd0, 1'b0, m_err};
      2:       exp_v = {8'b0000_0010, 1'b0, 2'd0, 1'b0, m_err};
      3:       exp_v = {8'b1111_1110, 1'b1, (mem_Jump ? 2'd2 : 2'd1), 1'b0, m_err};
      4:       exp_v = {8'b0011_1010, 1'b0, 2'd0, 1'b0, m_err};
      5:       exp_v = {8'b1110_1010, 1'b0, 2'd0, 1'b0, m_err};
      6:       exp_v = {8'b1010_1010, 1'b1, 2'd0, 1'b0, m_err};
      default: exp_v = '0;
    endcase
    exp_st = (rule == -1) ? 2'd0 : m_halt ? 2'd2 : m_wait ? 2'd1 : 2'd0;
`ifdef HAZARD_STATS_EN
    exp_stall = RST ? 32'd0 : m_stall;
    exp_flush = RST ? 32'd0 : m_flush;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    got_v = {ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
             memwb_flush, pc_en, pc_sel, halt_out, err};
    check("ctrl", 32'(got_v), 32'(exp_v));
    check("state", 32'(state_dbg), 32'(exp_st));
    check("stall_cycles", stall_cycles, exp_stall);
    check("flush_events", flush_events, exp_flush);
    if (RST) begin
      m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (!exp_v[4]) m_stall = m_stall + 1;
      if (rule == 3) m_flush = m_flush + 1;
      if (m_cnt == TO) m_err = 1;
      if (rule == 1) begin
        m_cnt  = m_wait ? ((m_cnt < TO) ? m_cnt + 1 : TO) : 0;
        m_wait = 1;
      end else begin
        m_cnt  = 0;
        m_wait = 0;
        if (rule == 2) m_halt = 1;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    m_wait = 0; m_halt = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    idle();
    RST = 1'b1;
    repeat (2) cycle();
    RST = 1'b0;
    repeat (4) cycle();

    mem_dREN = 1'b1; dhit = 1'b0;
    repeat (3) cycle();
    dhit = 1'b1;
    cycle();
    idle();
    cycle();

    ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8;
    cycle();
    ex_wsel = 5'd0; id_rt = 5'd0;
    cycle();
    idle();

    mem_Branch = 1'b1; mem_zero = 1'b1; ihit = 1'b0;
    cycle();
    mem_Jump = 1'b1;
    cycle();
    idle();
    cycle();

    mem_dWEN = 1'b1; dhit = 1'b0;
    repeat (6) cycle();
    idle();
    repeat (2) cycle();
    check("err_sticky", 32'(err), 32'd1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    cycle();
    check("err_cleared", 32'(err), 32'd0);

    mem_halt = 1'b1;
    cycle();
    repeat (12) begin
      rand_inputs();
      ihit = 1'b1;
      cycle();
    end
    check("halted_hold", 32'(halt_out), 32'd1);

    for (int r = 0; r < 25; r++) begin
      RST = 1'b1;
      rand_inputs();
      cycle();
      RST = 1'b0;
      repeat (60) begin
        rand_inputs();
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
